haraka_s_sponge_ctrl: RTL and testbench

Sequencing controller for the Haraka-S sponge. It accepts padded 256-bit rate blocks from the deserializer and drives the iterative Haraka permutation core round by round, selecting the constant group for each round. It then commands the state register to capture each permutation result. In the squeeze phase it issues length-tagged 256-bit output blocks to the serializer until `digest_length` bytes have been emitted.

---
 rtl/haraka_s_sponge_ctrl_if.sv | 34 +++
 rtl/haraka_s_sponge_ctrl.sv | 127 ++++++++++++
 tb/tb_haraka_s_sponge_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/haraka_s_sponge_ctrl_if.sv
// Handshake and control bundle between the Haraka-S sponge controller and its
// deserializer, permutation core, state register and serializer.
interface haraka_s_sponge_ctrl_if #(
    parameter int LEN_W = 64,
    parameter int RW    = 3
);
    logic             blk_valid;
    logic             blk_last;
    logic             blk_ready;
    logic [LEN_W-1:0] digest_length;
    logic             perm_start;
    logic             absorb_sel;
    logic [RW-1:0]    perm_round;
    logic             round_done;
    logic             state_load;
    logic             state_clear;
    logic             ser_valid;
    logic [5:0]       ser_length;
    logic             ser_ready;
    logic             busy;
    logic             done;

    modport master (
        input  blk_valid, blk_last, digest_length, round_done, ser_ready,
        output blk_ready, perm_start, absorb_sel, perm_round, state_load,
               state_clear, ser_valid, ser_length, busy, done
    );

    modport slave (
        output blk_valid, blk_last, digest_length, round_done, ser_ready,
        input  blk_ready, perm_start, absorb_sel, perm_round, state_load,
               state_clear, ser_valid, ser_length, busy, done
    );
endinterface

// File: rtl/haraka_s_sponge_ctrl.sv
// Haraka-S sponge sequencer: absorbs padded rate blocks, steps the iterative
// permutation core round by round, then squeezes length-tagged output blocks.
module haraka_s_sponge_ctrl #(
    parameter int ROUNDS = 5,
    parameter int LEN_W  = 64,
    parameter int RW     = 3
) (
    input  logic internal_clk,
    input  logic reset,
    haraka_s_sponge_ctrl_if.master sponge
);
    // One extra bit over LEN_W-5 so a maximal digest_length still fits its block count.
    localparam int REM_W = LEN_W - 4;

    typedef enum logic [2:0] {
        ABSORB, START, PERMUTE, LOAD, SQUEEZE, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     perm_round_q;
    logic [REM_W-1:0]  remaining_q;
    logic [4:0]        tail_len_q;
    logic              last_q;
    logic              absorb_q;

    logic blk_ready, perm_start, state_load, state_clear, ser_valid, done;
    logic last_round, last_block_out;

    assign last_round     = (perm_round_q == RW'(ROUNDS - 1));
    assign last_block_out = (remaining_q == REM_W'(1));

    always_ff @(posedge internal_clk or posedge reset) begin
        if (reset) state_q <= ABSORB;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        blk_ready   = 1'b0;
        perm_start  = 1'b0;
        state_load  = 1'b0;
        state_clear = 1'b0;
        ser_valid   = 1'b0;
        done        = 1'b0;
        case (state_q)
            ABSORB: begin
                blk_ready = 1'b1;
                if (sponge.blk_valid) state_d = START;
            end
            START: begin
                perm_start = 1'b1;
                state_d    = PERMUTE;
            end
            PERMUTE: begin
                if (sponge.round_done && last_round) state_d = LOAD;
            end
            LOAD: begin
                state_load = 1'b1;
                if (!last_q)                  state_d = ABSORB;
                else if (remaining_q != '0)   state_d = SQUEEZE;
                else                          state_d = DONE;
            end
            SQUEEZE: begin
                ser_valid = 1'b1;
                if (sponge.ser_ready) state_d = last_block_out ? DONE : START;
            end
            DONE: begin
                done        = 1'b1;
                state_clear = 1'b1;
                state_d     = ABSORB;
            end
            default: state_d = ABSORB;
        endcase
    end

    always_ff @(posedge internal_clk or posedge reset) begin
        if (reset) begin
            perm_round_q <= '0;
            remaining_q  <= '0;
            tail_len_q   <= '0;
            last_q       <= 1'b0;
            absorb_q     <= 1'b0;
        end else begin
            case (state_q)
                ABSORB: begin
                    if (sponge.blk_valid) begin
                        last_q     <= sponge.blk_last;
                        tail_len_q <= sponge.digest_length[4:0];
                        absorb_q   <= 1'b1;
                        if (sponge.blk_last)
                            remaining_q <= REM_W'(sponge.digest_length >> 5)
                                         + REM_W'(|sponge.digest_length[4:0]);
                    end
                end
                START: perm_round_q <= '0;
                PERMUTE: begin
                    if (sponge.round_done)
                        perm_round_q <= last_round ? '0 : perm_round_q + RW'(1);
                end
                SQUEEZE: begin
                    if (sponge.ser_ready) begin
                        remaining_q <= remaining_q - REM_W'(1);
                        if (!last_block_out) absorb_q <= 1'b0;
                    end
                end
                DONE: begin
                    last_q      <= 1'b0;
                    remaining_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Every output below depends only on registered state, never on an input.
    assign sponge.blk_ready   = blk_ready;
    assign sponge.perm_start  = perm_start;
    assign sponge.state_load  = state_load;
    assign sponge.state_clear = state_clear;
    assign sponge.ser_valid   = ser_valid;
    assign sponge.done        = done;
    assign sponge.busy        = (state_q != ABSORB);
    assign sponge.absorb_sel  = absorb_q && (state_q == START || state_q == PERMUTE);
    assign sponge.perm_round  = perm_round_q;
    assign sponge.ser_length  = (last_block_out && tail_len_q != 5'd0) ? {1'b0, tail_len_q}
                                                                       : 6'd32;
endmodule

// File: tb/tb_haraka_s_sponge_ctrl.sv
// Bench for haraka_s_sponge_ctrl: event-level expectation model checked every
// cycle, plus per-message literal expectations (pulse counts, output lengths).
module tb_haraka_s_sponge_ctrl;
    localparam int ROUNDS = 5;

    logic internal_clk;
    logic reset;
    logic core_rd, spur_rd, ser_hold;

    haraka_s_sponge_ctrl_if #(.LEN_W(64), .RW(3)) ifc ();

    haraka_s_sponge_ctrl #(.ROUNDS(ROUNDS), .LEN_W(64), .RW(3)) dut (
        .internal_clk (internal_clk),
        .reset        (reset),
        .sponge       (ifc)
    );

    assign ifc.round_done = core_rd | spur_rd;
    assign ifc.ser_ready  = !ser_hold;

    initial internal_clk = 1'b0;
    always #5 internal_clk = ~internal_clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Observations gathered per message for the literal checks
    int         n_starts;
    int         n_done_seen;
    logic [5:0] obs_lens[$];

    // Expectation model: what each output must be this cycle, derived from the
    // cause-and-effect timing of the sponge (accept -> start, 5 rounds -> load, ...)
    logic        m_ready, m_start, m_load, m_sv, m_done, m_inperm, m_abs, m_last;
    logic [2:0]  m_rc;
    logic [64:0] m_out_left;
    logic [4:0]  m_tail;

    initial begin
        forever begin
            @(negedge internal_clk);
            if (reset) begin
                check("rst_blk_ready",   ifc.blk_ready,   1);
                check("rst_perm_start",  ifc.perm_start,  0);
                check("rst_state_load",  ifc.state_load,  0);
                check("rst_state_clear", ifc.state_clear, 0);
                check("rst_ser_valid",   ifc.ser_valid,   0);
                check("rst_done",        ifc.done,        0);
                check("rst_busy",        ifc.busy,        0);
                check("rst_absorb_sel",  ifc.absorb_sel,  0);
                check("rst_ser_length",  ifc.ser_length,  32);
                check("rst_perm_round",  ifc.perm_round,  0);
                m_ready = 1; m_start = 0; m_load = 0; m_sv = 0; m_done = 0;
                m_inperm = 0; m_abs = 0; m_last = 0; m_rc = 0; m_out_left = 0; m_tail = 0;
            end else begin
                logic acc, take, rd, n_start, n_load, n_sv, n_done, n_ready;
                check("blk_ready",   ifc.blk_ready,   m_ready);
                check("busy",        ifc.busy,        !m_ready);
                check("perm_start",  ifc.perm_start,  m_start);
                check("state_load",  ifc.state_load,  m_load);
                check("ser_valid",   ifc.ser_valid,   m_sv);
                check("done",        ifc.done,        m_done);
                check("state_clear", ifc.state_clear, m_done);
                check("absorb_sel",  ifc.absorb_sel,  (m_start || m_inperm) ? m_abs : 1'b0);
                if (m_start || m_inperm) check("perm_round", ifc.perm_round, m_rc);
                if (m_sv) check("ser_length", ifc.ser_length,
                                (m_out_left == 1 && m_tail != 0) ? {1'b0, m_tail} : 6'd32);
                if (ifc.perm_start) n_starts++;
                if (ifc.done) n_done_seen++;

                acc  = m_ready && ifc.blk_valid;
                take = m_sv && ifc.ser_ready;
                rd   = m_inperm && ifc.round_done;
                if (take) obs_lens.push_back(ifc.ser_length);

                n_start = acc || (take && m_out_left > 1);
                n_load  = rd && (m_rc == ROUNDS - 1);
                n_sv    = (m_sv && !ifc.ser_ready) || (m_load && m_last && m_out_left != 0);
                n_done  = (take && m_out_left == 1) || (m_load && m_last && m_out_left == 0);
                n_ready = (m_ready && !ifc.blk_valid) || (m_load && !m_last) || m_done;

                if (acc) begin
                    m_last = ifc.blk_last;
                    m_tail = ifc.digest_length[4:0];
                    m_abs  = 1;
                    if (ifc.blk_last) m_out_left = ({1'b0, ifc.digest_length} + 65'd31) >> 5;
                end
                if (take) begin
                    if (m_out_left > 1) m_abs = 0;
                    m_out_left = m_out_left - 1;
                end
                if (m_done) begin
                    m_last = 0;
                    m_out_left = 0;
                end
                if (m_start) m_rc = 0;
                else if (rd) m_rc = (m_rc == ROUNDS - 1) ? 3'd0 : m_rc + 3'd1;
                m_inperm = m_start || (m_inperm && !n_load);
                m_start = n_start; m_load = n_load; m_sv = n_sv; m_done = n_done; m_ready = n_ready;
            end
        end
    end

    // Single-cycle permutation core: one round_done per cycle after each start
    initial begin
        core_rd = 1'b0;
        forever begin
            @(negedge internal_clk);
            if (ifc.perm_start && !reset) begin
                for (int r = 0; r < ROUNDS; r++) begin
                    @(posedge internal_clk); #1;
                    core_rd = 1'b1;
                end
                @(posedge internal_clk); #1;
                core_rd = 1'b0;
            end
        end
    end

    task automatic run_msg(input int nb, input logic [63:0] dl, input int bp,
                           input int exp_starts, input int exp_n,
                           input logic [5:0] l0, input logic [5:0] l1);
        time t_prev;
        int  t;
        logic [5:0] cap;
        t_prev = 0;
        n_starts = 0; n_done_seen = 0; obs_lens.delete();
        if (bp > 0) ser_hold = 1'b1;
        for (int i = 0; i < nb; i++) begin
            @(posedge internal_clk); #1;
            ifc.blk_valid = 1'b1;
            ifc.blk_last  = (i == nb - 1);
            ifc.digest_length = dl;
            t = 0;
            do begin
                @(negedge internal_clk);
                t++;
            end while (!(ifc.blk_ready && ifc.blk_valid) && t < 100);
            if (t >= 100) check("accept_timeout", 0, 1);
            if (i > 0) check("blk_interval", ($time - t_prev) / 10, ROUNDS + 3);
            t_prev = $time;
        end
        @(posedge internal_clk); #1;
        ifc.blk_valid = 1'b0;
        ifc.blk_last  = 1'b0;
        ifc.digest_length = 64'd999;
        if (bp > 0) begin
            t = 0;
            do begin
                @(negedge internal_clk);
                t++;
            end while (!ifc.ser_valid && t < 100);
            if (t >= 100) check("ser_valid_timeout", 0, 1);
            cap = ifc.ser_length;
            check("bp_len", cap, l0);
            for (int k = 0; k < bp; k++) begin
                @(posedge internal_clk); #1;
                spur_rd = 1'b1;
                @(negedge internal_clk);
                check("bp_ser_valid", ifc.ser_valid, 1);
                check("bp_ser_length", ifc.ser_length, cap);
            end
            @(posedge internal_clk); #1;
            ser_hold = 1'b0;
            spur_rd  = 1'b0;
        end
        t = 0;
        do begin
            @(negedge internal_clk);
            t++;
        end while (!ifc.done && t < 300);
        if (t >= 300) check("done_timeout", 0, 1);
        @(posedge internal_clk); #1;
        check("perm_starts", n_starts, exp_starts);
        check("done_pulses", n_done_seen, 1);
        check("out_blocks", obs_lens.size(), exp_n);
        if (exp_n > 0) check("len0", obs_lens[0], l0);
        if (exp_n > 1) check("len1", obs_lens[1], l1);
    endtask

    initial begin
        int t;
        reset = 1'b1;
        spur_rd = 1'b0;
        ser_hold = 1'b0;
        ifc.blk_valid = 1'b0;
        ifc.blk_last = 1'b0;
        ifc.digest_length = '0;
        repeat (3) @(posedge internal_clk);
        #2 reset = 1'b0;

        run_msg(1, 64'd64, 0, 2, 2, 6'd32, 6'd32);
        run_msg(1, 64'd40, 0, 2, 2, 6'd32, 6'd8);
        run_msg(1, 64'd5,  0, 1, 1, 6'd5,  6'd0);
        run_msg(1, 64'd0,  0, 1, 0, 6'd0,  6'd0);
        run_msg(3, 64'd32, 0, 3, 1, 6'd32, 6'd0);
        run_msg(1, 64'd40, 10, 2, 2, 6'd32, 6'd8);

        // Asynchronous reset in the middle of a permutation
        @(posedge internal_clk); #1;
        ifc.blk_valid = 1'b1;
        ifc.blk_last  = 1'b1;
        ifc.digest_length = 64'd64;
        @(negedge internal_clk);
        @(posedge internal_clk); #1;
        ifc.blk_valid = 1'b0;
        ifc.blk_last  = 1'b0;
        t = 0;
        do begin
            @(negedge internal_clk);
            t++;
        end while (ifc.perm_round != 3'd3 && t < 50);
        if (t >= 50) check("round3_timeout", 0, 1);
        #1 reset = 1'b1;
        #1;
        check("async_blk_ready",  ifc.blk_ready,  1);
        check("async_busy",       ifc.busy,       0);
        check("async_perm_round", ifc.perm_round, 0);
        check("async_absorb_sel", ifc.absorb_sel, 0);
        check("async_ser_length", ifc.ser_length, 32);
        repeat (2) @(posedge internal_clk);
        #2 reset = 1'b0;
        repeat (8) @(posedge internal_clk);
        run_msg(1, 64'd5, 0, 1, 1, 6'd5, 6'd0);

        repeat (3) @(posedge internal_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion (passed %0d of %0d)", n_pass, n_total);
        $fatal(1, "watchdog");
    end
endmodule
